riscv_byp_hazard_ctrl: RTL and testbench

Bypass and hazard controller for the 5-stage RISC-V bypassing datapath. It tracks the destination register of every in-flight instruction in X, M and W and drives the datapath's operand-source selects (`rs1_Src`/`rs2_Src`). It generates per-stage stalls and bubble insertion and sequences the iterative multiply/divide unit's request/response handshake. It sits beside the decode control logic, consumes decoded D-stage fields, and drives the datapath's stall, bypass and writeback-address inputs.

---
 rtl/riscv_byp_hazard_ctrl_pkg.sv | 34 +++
 rtl/riscv_byp_hazard_ctrl_muldiv_seq.sv | 52 +++++
 rtl/riscv_byp_hazard_ctrl.sv | 134 +++++++++++++
 tb/tb_riscv_byp_hazard_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_byp_hazard_ctrl_pkg.sv
// Shared types for the bypass/hazard controller: operand-source codes, muldiv
// sequencer states and the per-stage scoreboard entry.
package riscv_byp_hazard_ctrl_pkg;

    localparam int unsigned REG_AW = 5;

    localparam logic [2:0] SRC_RF = 3'b000;
    localparam logic [2:0] SRC_X  = 3'b001;
    localparam logic [2:0] SRC_M  = 3'b010;
    localparam logic [2:0] SRC_W  = 3'b011;

    typedef enum logic {
        StIdle = 1'b0,
        StBusy = 1'b1
    } md_state_e;

    typedef struct packed {
        logic              val;
        logic              wen;
        logic [REG_AW-1:0] rd;
        logic              is_load;
        logic              is_muldiv;
    } sb_entry_t;

    function automatic logic sb_wr(input sb_entry_t e);
        return e.val & e.wen & (e.rd != '0);
    endfunction

    function automatic logic sb_hit(input sb_entry_t e, input logic en,
                                    input logic [REG_AW-1:0] rs);
        return en & (rs != '0) & sb_wr(e) & (e.rd == rs);
    endfunction

endpackage

// File: rtl/riscv_byp_hazard_ctrl_muldiv_seq.sv
// Request/response sequencer for the iterative muldiv unit; also reports
// whether the muldiv instruction in X must keep X held.
module riscv_byp_muldiv_seq
    import riscv_byp_hazard_ctrl_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic x_muldiv,
    input  logic stall_Mhl,
    input  logic muldivreq_rdy,
    input  logic muldivresp_val,
    output logic muldivreq_val,
    output logic muldivresp_rdy,
    output logic muldiv_wait
);

    md_state_e state_q, state_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        muldivreq_val  = 1'b0;
        muldivresp_rdy = 1'b0;
        muldiv_wait    = 1'b0;
        unique case (state_q)
            StIdle: begin
                muldivreq_val = x_muldiv;
                muldiv_wait   = x_muldiv;
                if (x_muldiv && muldivreq_rdy) begin
                    state_d = StBusy;
                end
            end
            StBusy: begin
                // The result can only be taken when M is free to receive it.
                muldivresp_rdy = !stall_Mhl;
                muldiv_wait    = !(muldivresp_val && !stall_Mhl);
                if (muldivresp_val && !stall_Mhl) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: rtl/riscv_byp_hazard_ctrl.sv
// Bypass/hazard controller for the 5-stage bypassing pipeline. Define
// RISCV_BYP_FULL_BYPASS_EN for full bypassing; otherwise D interlocks on any RAW.
module riscv_byp_hazard_ctrl
    import riscv_byp_hazard_ctrl_pkg::*;
#(
    parameter int unsigned NREGS = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     inst_val_Dhl,
    input  logic                     rs1_en_Dhl,
    input  logic                     rs2_en_Dhl,
    input  logic [$clog2(NREGS)-1:0] rs1_Dhl,
    input  logic [$clog2(NREGS)-1:0] rs2_Dhl,
    input  logic [$clog2(NREGS)-1:0] rd_Dhl,
    input  logic                     rf_wen_Dhl,
    input  logic                     is_load_Dhl,
    input  logic                     is_muldiv_Dhl,
    input  logic                     squash_Dhl,
    input  logic                     dmem_stall_Mhl,
    input  logic                     muldivreq_rdy,
    input  logic                     muldivresp_val,
    output logic                     muldivreq_val,
    output logic                     muldivresp_rdy,
    output logic [2:0]               rs1_Src,
    output logic [2:0]               rs2_Src,
    output logic                     stall_Fhl,
    output logic                     stall_Dhl,
    output logic                     stall_Xhl,
    output logic                     stall_Mhl,
    output logic                     stall_Whl,
    output logic                     rf_wen_Whl,
    output logic [$clog2(NREGS)-1:0] rf_waddr_Whl
);

    sb_entry_t x_q, m_q, w_q;
    sb_entry_t x_d, m_d, w_d;
    logic      d_dead_q, d_dead_d;
    logic      muldiv_wait;
    logic      hit1_x, hit1_m, hit1_w, hit2_x, hit2_m, hit2_w;
    logic      d_hazard;
    logic      unused_fields;

    assign hit1_x = sb_hit(x_q, rs1_en_Dhl, rs1_Dhl);
    assign hit1_m = sb_hit(m_q, rs1_en_Dhl, rs1_Dhl);
    assign hit1_w = sb_hit(w_q, rs1_en_Dhl, rs1_Dhl);
    assign hit2_x = sb_hit(x_q, rs2_en_Dhl, rs2_Dhl);
    assign hit2_m = sb_hit(m_q, rs2_en_Dhl, rs2_Dhl);
    assign hit2_w = sb_hit(w_q, rs2_en_Dhl, rs2_Dhl);

`ifdef RISCV_BYP_FULL_BYPASS_EN
    always_comb begin
        rs1_Src = hit1_x ? SRC_X : hit1_m ? SRC_M : hit1_w ? SRC_W : SRC_RF;
        rs2_Src = hit2_x ? SRC_X : hit2_m ? SRC_M : hit2_w ? SRC_W : SRC_RF;
        // Loads and muldivs have no result to forward while still in X.
        d_hazard = (hit1_x | hit2_x) & (x_q.is_load | x_q.is_muldiv);
    end
`else
    always_comb begin
        rs1_Src  = SRC_RF;
        rs2_Src  = SRC_RF;
        d_hazard = hit1_x | hit1_m | hit1_w | hit2_x | hit2_m | hit2_w;
    end
`endif

    assign stall_Whl = 1'b0;
    assign stall_Mhl = dmem_stall_Mhl;
    assign stall_Xhl = stall_Mhl | muldiv_wait;
    assign stall_Dhl = inst_val_Dhl & (stall_Xhl | d_hazard);
    assign stall_Fhl = stall_Dhl;

    assign rf_wen_Whl   = sb_wr(w_q);
    assign rf_waddr_Whl = w_q.rd;

    assign unused_fields = ^{w_q.is_load, w_q.is_muldiv, x_q.is_load};

    always_comb begin
        x_d = x_q;
        if (!stall_Xhl) begin
            if (stall_Dhl || squash_Dhl || !inst_val_Dhl || d_dead_q) begin
                x_d = '0;
            end else begin
                x_d.val       = 1'b1;
                x_d.wen       = rf_wen_Dhl;
                x_d.rd        = rd_Dhl;
                x_d.is_load   = is_load_Dhl;
                x_d.is_muldiv = is_muldiv_Dhl;
            end
        end

        m_d = m_q;
        if (!stall_Mhl) begin
            m_d = stall_Xhl ? '0 : x_q;
        end

        // A held M must not be written back twice.
        w_d = stall_Mhl ? '0 : m_q;

        // A squashed D that stays in D is remembered as dead until it leaves.
        d_dead_d = d_dead_q;
        if (squash_Dhl && stall_Dhl) begin
            d_dead_d = 1'b1;
        end else if (!stall_Dhl) begin
            d_dead_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_q      <= '0;
            m_q      <= '0;
            w_q      <= '0;
            d_dead_q <= 1'b0;
        end else begin
            x_q      <= x_d;
            m_q      <= m_d;
            w_q      <= w_d;
            d_dead_q <= d_dead_d;
        end
    end

    riscv_byp_muldiv_seq u_muldiv_seq (
        .clk            (clk),
        .reset          (reset),
        .x_muldiv       (x_q.val & x_q.is_muldiv),
        .stall_Mhl      (stall_Mhl),
        .muldivreq_rdy  (muldivreq_rdy),
        .muldivresp_val (muldivresp_val),
        .muldivreq_val  (muldivreq_val),
        .muldivresp_rdy (muldivresp_rdy),
        .muldiv_wait    (muldiv_wait)
    );

endmodule

// File: tb/tb_riscv_byp_hazard_ctrl.sv
// Directed bench for riscv_byp_hazard_ctrl; expectations follow the build's
// RISCV_BYP_FULL_BYPASS_EN setting.
module tb_riscv_byp_hazard_ctrl;

`ifdef RISCV_BYP_FULL_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       inst_val_Dhl, rs1_en_Dhl, rs2_en_Dhl, rf_wen_Dhl;
    logic [4:0] rs1_Dhl, rs2_Dhl, rd_Dhl;
    logic       is_load_Dhl, is_muldiv_Dhl, squash_Dhl, dmem_stall_Mhl;
    logic       muldivreq_rdy, muldivresp_val, muldivreq_val, muldivresp_rdy;
    logic [2:0] rs1_Src, rs2_Src;
    logic       stall_Fhl, stall_Dhl, stall_Xhl, stall_Mhl, stall_Whl;
    logic       rf_wen_Whl;
    logic [4:0] rf_waddr_Whl;

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    riscv_byp_hazard_ctrl #(.NREGS(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .inst_val_Dhl   (inst_val_Dhl),
        .rs1_en_Dhl     (rs1_en_Dhl),
        .rs2_en_Dhl     (rs2_en_Dhl),
        .rs1_Dhl        (rs1_Dhl),
        .rs2_Dhl        (rs2_Dhl),
        .rd_Dhl         (rd_Dhl),
        .rf_wen_Dhl     (rf_wen_Dhl),
        .is_load_Dhl    (is_load_Dhl),
        .is_muldiv_Dhl  (is_muldiv_Dhl),
        .squash_Dhl     (squash_Dhl),
        .dmem_stall_Mhl (dmem_stall_Mhl),
        .muldivreq_rdy  (muldivreq_rdy),
        .muldivresp_val (muldivresp_val),
        .muldivreq_val  (muldivreq_val),
        .muldivresp_rdy (muldivresp_rdy),
        .rs1_Src        (rs1_Src),
        .rs2_Src        (rs2_Src),
        .stall_Fhl      (stall_Fhl),
        .stall_Dhl      (stall_Dhl),
        .stall_Xhl      (stall_Xhl),
        .stall_Mhl      (stall_Mhl),
        .stall_Whl      (stall_Whl),
        .rf_wen_Whl     (rf_wen_Whl),
        .rf_waddr_Whl   (rf_waddr_Whl)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed=%0h required=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input int val, input int e1, input int r1, input int e2, input int r2,
                         input int rd, input int wen, input int ld, input int md);
        inst_val_Dhl  = 1'(val);
        rs1_en_Dhl    = 1'(e1);
        rs1_Dhl       = 5'(r1);
        rs2_en_Dhl    = 1'(e2);
        rs2_Dhl       = 5'(r2);
        rd_Dhl        = 5'(rd);
        rf_wen_Dhl    = 1'(wen);
        is_load_Dhl   = 1'(ld);
        is_muldiv_Dhl = 1'(md);
    endtask

    task automatic nop_d;
        set_d(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Issue one instruction into X, leaving D empty afterwards.
    task automatic issue(input int rd, input int wen, input int ld, input int md);
        set_d(1, 0, 0, 0, 0, rd, wen, ld, md);
        tick();
        nop_d();
    endtask

    // Present a non-writing reader in D, check selects/stall, then withdraw it.
    task automatic probe(input string tag, input int e1, input int r1, input int e2, input int r2,
                         input int s1, input int s2, input int st);
        set_d(1, e1, r1, e2, r2, 0, 0, 0, 0);
        #1;
        chk({tag, ".rs1_Src"}, 32'(rs1_Src), s1);
        chk({tag, ".rs2_Src"}, 32'(rs2_Src), s2);
        chk({tag, ".stall_Dhl"}, 32'(stall_Dhl), st);
        nop_d();
    endtask

    task automatic drain;
        repeat (3) tick();
    endtask

    initial begin
        reset          = 1'b0;
        squash_Dhl     = 1'b0;
        dmem_stall_Mhl = 1'b0;
        muldivreq_rdy  = 1'b0;
        muldivresp_val = 1'b0;
        set_d(1, 1, 5, 1, 6, 7, 1, 1, 1);
        repeat (2) @(posedge clk);
        #2;
        chk("rst.rs1_Src", 32'(rs1_Src), 0);
        chk("rst.rs2_Src", 32'(rs2_Src), 0);
        chk("rst.stall_Dhl", 32'(stall_Dhl), 0);
        chk("rst.stall_Xhl", 32'(stall_Xhl), 0);
        chk("rst.reqval", 32'(muldivreq_val), 0);
        chk("rst.resprdy", 32'(muldivresp_rdy), 0);
        chk("rst.rf_wen", 32'(rf_wen_Whl), 0);
        chk("rst.rf_waddr", 32'(rf_waddr_Whl), 0);
        nop_d();
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Producer add x5 walks X -> M -> W.
        issue(5, 1, 0, 0);
        probe("A.x1", 1, 5, 0, 0, BYP ? 1 : 0, 0, BYP ? 0 : 1);
        probe("A.x2", 0, 0, 1, 5, 0, BYP ? 1 : 0, BYP ? 0 : 1);
        probe("A.dis", 0, 5, 0, 5, 0, 0, 0);
        tick();
        probe("A.m", 1, 5, 0, 0, BYP ? 2 : 0, 0, BYP ? 0 : 1);
        tick();
        probe("A.w", 1, 5, 0, 0, BYP ? 3 : 0, 0, BYP ? 0 : 1);
        chk("A.w.rf_wen", 32'(rf_wen_Whl), 1);
        chk("A.w.rf_waddr", 32'(rf_waddr_Whl), 5);
        chk("A.w.stall_Whl", 32'(stall_Whl), 0);
        tick();
        probe("A.none", 1, 5, 0, 0, 0, 0, 0);
        chk("A.none.rf_wen", 32'(rf_wen_Whl), 0);
        issue(5, 1, 0, 0);
        issue(5, 1, 0, 0);
        probe("A.prio", 1, 5, 1, 5, BYP ? 1 : 0, BYP ? 1 : 0, BYP ? 0 : 1);
        drain();

        // Load-use: exactly one bubble, then bypass from M.
        issue(6, 1, 1, 0);
        set_d(1, 0, 0, 1, 6, 0, 0, 0, 0);
        #1;
        chk("B.lu.stall_Dhl", 32'(stall_Dhl), 1);
        chk("B.lu.stall_Fhl", 32'(stall_Fhl), 1);
        chk("B.lu.stall_Xhl", 32'(stall_Xhl), 0);
        tick();
        chk("B.after.stall_Dhl", 32'(stall_Dhl), BYP ? 0 : 1);
        chk("B.after.rs2_Src", 32'(rs2_Src), BYP ? 2 : 0);
        nop_d();
        drain();

        // Muldiv: X held for 8 cycles until the response handshake.
        issue(7, 1, 0, 1);
        muldivreq_rdy = 1'b1;
        #1;
        chk("C.req.reqval", 32'(muldivreq_val), 1);
        chk("C.req.stall_Xhl", 32'(stall_Xhl), 1);
        chk("C.req.resprdy", 32'(muldivresp_rdy), 0);
        for (int i = 0; i < 7; i++) begin
            tick();
            muldivreq_rdy = 1'b0;
            #1;
            chk("C.busy.stall_Xhl", 32'(stall_Xhl), 1);
            chk("C.busy.resprdy", 32'(muldivresp_rdy), 1);
            chk("C.busy.reqval", 32'(muldivreq_val), 0);
        end
        tick();
        muldivresp_val = 1'b1;
        set_d(1, 1, 7, 0, 0, 0, 0, 0, 0);
        #1;
        chk("C.resp.stall_Xhl", 32'(stall_Xhl), 0);
        chk("C.resp.stall_Dhl", 32'(stall_Dhl), 1);
        tick();
        muldivresp_val = 1'b0;
        #1;
        chk("C.use.rs1_Src", 32'(rs1_Src), BYP ? 2 : 0);
        chk("C.use.stall_Dhl", 32'(stall_Dhl), BYP ? 0 : 1);
        chk("C.use.resprdy", 32'(muldivresp_rdy), 0);
        nop_d();
        drain();

        // Writes to x0 never forward and never reach the regfile.
        issue(0, 1, 0, 0);
        set_d(1, 1, 0, 0, 0, 0, 1, 0, 0);
        #1;
        chk("D.x0.rs1_Src", 32'(rs1_Src), 0);
        chk("D.x0.stall_Dhl", 32'(stall_Dhl), 0);
        tick();
        nop_d();
        tick();
        chk("D.w1.rf_wen", 32'(rf_wen_Whl), 0);
        tick();
        chk("D.w2.rf_wen", 32'(rf_wen_Whl), 0);
        drain();

        // Data-memory stall for 3 cycles; W sees bubbles, then x10/x11/x12 in order.
        issue(10, 1, 0, 0);
        issue(11, 1, 0, 0);
        dmem_stall_Mhl = 1'b1;
        set_d(1, 0, 0, 0, 0, 12, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            if (i != 0) tick();
            #1;
            chk("E.st.stall_Fhl", 32'(stall_Fhl), 1);
            chk("E.st.stall_Dhl", 32'(stall_Dhl), 1);
            chk("E.st.stall_Xhl", 32'(stall_Xhl), 1);
            chk("E.st.stall_Mhl", 32'(stall_Mhl), 1);
            chk("E.st.stall_Whl", 32'(stall_Whl), 0);
            chk("E.st.rf_wen", 32'(rf_wen_Whl), 0);
        end
        tick();
        dmem_stall_Mhl = 1'b0;
        #1;
        chk("E.go.stall_Dhl", 32'(stall_Dhl), 0);
        chk("E.go.rf_wen", 32'(rf_wen_Whl), 0);
        tick();
        nop_d();
        chk("E.w10.rf_wen", 32'(rf_wen_Whl), 1);
        chk("E.w10.rf_waddr", 32'(rf_waddr_Whl), 10);
        tick();
        chk("E.w11.rf_waddr", 32'(rf_waddr_Whl), 11);
        tick();
        chk("E.w12.rf_waddr", 32'(rf_waddr_Whl), 12);
        drain();

        // Reset in the middle of a muldiv; the late response is ignored.
        issue(13, 1, 0, 1);
        muldivreq_rdy = 1'b1;
        tick();
        muldivreq_rdy = 1'b0;
        #1;
        chk("F.busy.resprdy", 32'(muldivresp_rdy), 1);
        reset = 1'b0;
        #1;
        chk("F.rst.resprdy", 32'(muldivresp_rdy), 0);
        chk("F.rst.reqval", 32'(muldivreq_val), 0);
        chk("F.rst.stall_Xhl", 32'(stall_Xhl), 0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        muldivresp_val = 1'b1;
        #1;
        chk("F.late.resprdy", 32'(muldivresp_rdy), 0);
        chk("F.late.stall_Xhl", 32'(stall_Xhl), 0);
        tick();
        muldivresp_val = 1'b0;
        #1;
        chk("F.after.resprdy", 32'(muldivresp_rdy), 0);
        chk("F.after.reqval", 32'(muldivreq_val), 0);

        // Squash: free X gets a bubble; stalled X marks D dead.
        set_d(1, 0, 0, 0, 0, 17, 1, 0, 0);
        squash_Dhl = 1'b1;
        #1;
        chk("G.sq.stall_Dhl", 32'(stall_Dhl), 0);
        tick();
        squash_Dhl = 1'b0;
        nop_d();
        probe("G.sq", 1, 17, 0, 0, 0, 0, 0);
        issue(16, 1, 0, 1);
        muldivreq_rdy = 1'b1;
        set_d(1, 0, 0, 0, 0, 15, 1, 0, 0);
        squash_Dhl = 1'b1;
        #1;
        chk("G.dead.stall_Dhl", 32'(stall_Dhl), 1);
        tick();
        squash_Dhl     = 1'b0;
        muldivreq_rdy  = 1'b0;
        muldivresp_val = 1'b1;
        #1;
        chk("G.resp.stall_Dhl", 32'(stall_Dhl), 0);
        tick();
        muldivresp_val = 1'b0;
        nop_d();
        probe("G.x15", 1, 15, 0, 0, 0, 0, 0);
        probe("G.x16", 1, 16, 0, 0, BYP ? 2 : 0, 0, BYP ? 0 : 1);
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
